// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry constants
// and the parity helper used by both the RX and TX engines.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    DONE  = 2'd3
  } uart_state_t;

  localparam int START_BITS     = 1;
  localparam int STOP_BITS      = 1;
  localparam int MAX_FRAME_BITS = 11;
  localparam int SHIFT_W        = 10;

  // Expected parity bit for a character; bit 7 must already be 0 in 7-bit mode.
  function automatic logic parity_bit(input logic [7:0] i_data, input logic i_odd);
    return (^i_data) ^ i_odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-time counter: ticks once every target clocks, where target is k or k>>1.
// Clearing restarts the period so the first tick lands exactly target clocks later.
module uart_bit_timer #(
  parameter int KW = 19
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_half,
  input  logic [KW-1:0] i_k,
  output logic          o_tick
);

  logic [KW-1:0] r_cnt;
  logic [KW-1:0] w_target;

  assign w_target = i_half ? (i_k >> 1) : i_k;
  assign o_tick   = (r_cnt == w_target - KW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + KW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: start-bit verify at half a bit, mid-bit sampling, status flags.
// Optional macro UART_RX_SYNC_EN adds a 2-flop input synchroniser (+2 cycles latency).
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int KW = 19
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          RX,
  input  logic          EIGHT,
  input  logic          PEN,
  input  logic          OHEL,
  input  logic [KW-1:0] k,
  input  logic          READS,
  output logic [7:0]    UART_RDATA,
  output logic          RXRDY,
  output logic          PERR,
  output logic          FERR,
  output logic          OVF
);

  uart_state_t          r_state;
  uart_state_t          w_next_state;
  logic                 w_rx;
  logic                 w_tick;
  logic                 w_clear;
  logic                 w_half;
  logic                 r_eight;
  logic                 r_pen;
  logic                 r_ohel;
  logic [3:0]           r_bitcnt;
  logic [3:0]           w_nsamp;
  logic [SHIFT_W-1:0]   r_shift;
  logic [SHIFT_W-1:0]   w_frame;
  logic [7:0]           w_data;
  logic                 w_rx_par;
  logic                 w_stop;

`ifdef UART_RX_SYNC_EN
  logic r_rx_meta;
  logic r_rx_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rx_sync <= r_rx_meta;
    end
  end

  assign w_rx = r_rx_sync;
`else
  assign w_rx = RX;
`endif

  // Counter restarts on every state entry and is held clear while idle.
  assign w_clear = (w_next_state != r_state) || (r_state == IDLE);
  assign w_half  = (r_state == START);

  uart_bit_timer #(
    .KW (KW)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .i_half  (w_half),
    .i_k     (k),
    .o_tick  (w_tick)
  );

  // Samples after the start bit: data + optional parity + stop (8..10).
  assign w_nsamp = 4'(MAX_FRAME_BITS - START_BITS) - {3'b000, ~r_eight} - {3'b000, ~r_pen};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (!w_rx) w_next_state = START;
      START:   if (w_tick) w_next_state = w_rx ? IDLE : DATA;
      DATA:    if (w_tick && (r_bitcnt == w_nsamp - 4'd1)) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_eight  <= 1'b0;
      r_pen    <= 1'b0;
      r_ohel   <= 1'b0;
      r_bitcnt <= '0;
      r_shift  <= '1;
    end else if ((r_state == START) && w_tick && !w_rx) begin
      r_eight  <= EIGHT;
      r_pen    <= PEN;
      r_ohel   <= OHEL;
      r_bitcnt <= '0;
    end else if ((r_state == DATA) && w_tick) begin
      r_shift  <= {w_rx, r_shift[SHIFT_W-1:1]};
      r_bitcnt <= r_bitcnt + 4'd1;
    end
  end

  // Captured bits sit in the top w_nsamp positions; shift them down to bit 0.
  assign w_frame  = r_shift >> (4'(SHIFT_W) - w_nsamp);
  assign w_data   = r_eight ? w_frame[7:0] : {1'b0, w_frame[6:0]};
  assign w_rx_par = r_eight ? w_frame[8] : w_frame[7];
  assign w_stop   = w_frame[w_nsamp - 4'(STOP_BITS)];

  // A read in the same cycle as DONE is ordered before the new character.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      UART_RDATA <= '0;
      RXRDY      <= 1'b0;
      PERR       <= 1'b0;
      FERR       <= 1'b0;
      OVF        <= 1'b0;
    end else if (r_state == DONE) begin
      UART_RDATA <= w_data;
      RXRDY      <= 1'b1;
      PERR       <= r_pen && (w_rx_par != parity_bit(w_data, r_ohel));
      FERR       <= ~w_stop;
      OVF        <= RXRDY && !READS;
    end else if (READS) begin
      RXRDY      <= 1'b0;
      PERR       <= 1'b0;
      FERR       <= 1'b0;
      OVF        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Self-checking bench for uart_rx_engine: directed frames plus randomized traffic
// compared against a frame-level reference model. Honours UART_RX_SYNC_EN.
module tb_uart_rx_engine;

  localparam int KW = 19;
  localparam int W  = 11;
`ifdef UART_RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          RX;
  logic          EIGHT;
  logic          PEN;
  logic          OHEL;
  logic [KW-1:0] kk;
  logic          READS;
  logic [7:0]    UART_RDATA;
  logic          RXRDY;
  logic          PERR;
  logic          FERR;
  logic          OVF;

  int            checks = 0;
  int            errors = 0;
  longint        cyc = 0;
  logic          rdy_prev = 1'b0;
  logic [W-1:0]  exp_q[$];
  longint        exp_t_q[$];
  longint        rise_q[$];
  logic          m_rxrdy;
  logic [7:0]    last_data;
  logic          cfg_eight;
  logic          cfg_pen;
  logic          cfg_ohel;
  logic          scramble;

  always #5 clk = ~clk;

  uart_rx_engine #(.KW(KW)) dut (
    .clk        (clk),
    .rst        (rst),
    .RX         (RX),
    .EIGHT      (EIGHT),
    .PEN        (PEN),
    .OHEL       (OHEL),
    .k          (kk),
    .READS      (READS),
    .UART_RDATA (UART_RDATA),
    .RXRDY      (RXRDY),
    .PERR       (PERR),
    .FERR       (FERR),
    .OVF        (OVF)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Record the edge index at which RXRDY rises.
  always @(posedge clk) begin
    #1;
    if (RXRDY === 1'b1 && rdy_prev !== 1'b1) rise_q.push_back(cyc);
    rdy_prev = RXRDY;
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic e8, input logic pe, input logic od);
    cfg_eight = e8; cfg_pen = pe; cfg_ohel = od;
    EIGHT = e8; PEN = pe; OHEL = od;
  endtask

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one complete frame; called and returning just after a falling edge.
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop_b,
                            input bit read_at_done);
    bit         bits[$];
    logic [7:0] dm;
    int         nd;
    int         n;
    longint     t0;
    longint     e;
    logic       ovf;
    dm = cfg_eight ? d : {1'b0, d[6:0]};
    nd = cfg_eight ? 8 : 7;
    bits.push_back(1'b0);
    for (int i = 0; i < nd; i++) bits.push_back(dm[i]);
    if (cfg_pen) bits.push_back((^dm) ^ cfg_ohel ^ bad_par);
    bits.push_back(stop_b);
    n  = bits.size();
    t0 = cyc + 1;
    e  = t0 + longint'(kk >> 1) + longint'(n - 1) * longint'(kk) + 1 + SYNC_LAT;
    ovf = m_rxrdy && !read_at_done;
    exp_q.push_back({ovf, ~stop_b, cfg_pen & bad_par, dm});
    exp_t_q.push_back(m_rxrdy ? -64'sd1 : e);
    m_rxrdy = 1'b1;
    last_data = dm;
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < int'(kk); c++) begin
        RX = bits[b];
        if (scramble && b > 0) begin
          EIGHT = 1'($urandom_range(0, 1));
          PEN   = 1'($urandom_range(0, 1));
          OHEL  = 1'($urandom_range(0, 1));
        end
        READS = read_at_done && (cyc + 1 == e);
        @(negedge clk);
      end
    end
    READS = 1'b0;
    EIGHT = cfg_eight; PEN = cfg_pen; OHEL = cfg_ohel;
  endtask

  task automatic check_frame(input string tag);
    logic [W-1:0] ex;
    longint       et;
    longint       ot;
    ex = exp_q.pop_front();
    et = exp_t_q.pop_front();
    ot = (rise_q.size() > 0) ? rise_q.pop_front() : -64'sd1;
    check({tag, "_data"}, 64'(UART_RDATA), 64'(ex[7:0]));
    check({tag, "_rxrdy"}, 64'(RXRDY), 64'd1);
    check({tag, "_perr"}, 64'(PERR), 64'(ex[8]));
    check({tag, "_ferr"}, 64'(FERR), 64'(ex[9]));
    check({tag, "_ovf"}, 64'(OVF), 64'(ex[10]));
    check({tag, "_rise_cycle"}, 64'(ot), 64'(et));
  endtask

  task automatic do_read(input string tag);
    READS = 1'b1;
    @(negedge clk);
    READS = 1'b0;
    m_rxrdy = 1'b0;
    check({tag, "_rd_flags"}, 64'({RXRDY, PERR, FERR, OVF}), 64'd0);
    check({tag, "_rd_data_held"}, 64'(UART_RDATA), 64'(last_data));
  endtask

  initial begin
    rst = 1'b1; RX = 1'b1; READS = 1'b0; kk = KW'(16); scramble = 1'b0;
    m_rxrdy = 1'b0; last_data = 8'h00;
    set_cfg(1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({UART_RDATA, RXRDY, PERR, FERR, OVF}), 64'd0);
    rst = 1'b0;
    idle(4);

    // 8N1 basic character and read-back clear
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    check_frame("t1_8n1");
    do_read("t1");
    idle(8);

    // 7-bit even parity, wrong then correct parity bit
    set_cfg(1'b0, 1'b1, 1'b0);
    send_frame(8'h35, 1'b1, 1'b1, 1'b0);
    check_frame("t2_badpar");
    do_read("t2a");
    idle(8);
    send_frame(8'h35, 1'b0, 1'b1, 1'b0);
    check_frame("t2_goodpar");
    do_read("t2b");
    idle(8);

    // Framing error; idle long enough to absorb the low stop bit
    set_cfg(1'b1, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    check_frame("t3_ferr");
    do_read("t3");
    idle(40);
    check("t3_no_ghost_frame", 64'(rise_q.size()), 64'd0);

    // Back-to-back frames: overrun, then a read on the DONE cycle
    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    check_frame("t4_first");
    send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    check_frame("t4_overrun");
    do_read("t4a");
    idle(8);
    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    check_frame("t4_first_b");
    send_frame(8'h22, 1'b0, 1'b1, 1'b1);
    check_frame("t4_read_at_done");
    do_read("t4b");
    idle(8);

    // False start shorter than half a bit, then a valid frame
    RX = 1'b0;
    repeat (5) @(negedge clk);
    idle(40);
    check("t5_false_start_rxrdy", 64'(RXRDY), 64'd0);
    check("t5_false_start_rise", 64'(rise_q.size()), 64'd0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    check_frame("t5_after_false");

    // Reset in the middle of DATA aborts the frame
    idle(8);
    RX = 1'b0;
    repeat (16) @(negedge clk);
    RX = 1'b1;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_reset_outputs", 64'({UART_RDATA, RXRDY, PERR, FERR, OVF}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_rxrdy = 1'b0;
    last_data = 8'h00;
    idle(200);
    check("t6_no_rise_after_abort", 64'(rise_q.size()), 64'd0);

    // Randomized traffic with configuration pins toggling mid-frame
    scramble = 1'b1;
    for (int r = 0; r < 24; r++) begin
      kk = KW'($urandom_range(6, 40));
      set_cfg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      idle(4);
      send_frame(8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 3) == 0));
      check_frame($sformatf("rnd%0d", r));
      if ($urandom_range(0, 1) == 1) do_read($sformatf("rnd%0d", r));
      idle(2 * int'(kk));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
